// File: rtl/apb_per_bridge_pkg.sv
// Shared types and constants for the req/gnt to APB4 peripheral bridge.
package apb_per_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase cycle counter; flags expiry at TIMEOUT_CYCLES-1 (0 disables).
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CW        = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIMIT_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] LIMIT   = CW'(LIMIT_INT);
  localparam bit ENABLED            = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = ENABLED && (cnt_q == LIMIT);

endmodule

// File: rtl/apb_per_bridge.sv
// Single-outstanding bridge from the req/gnt/r_valid peripheral port to an APB4 master.
// State | meaning
// IDLE   | waiting for req_i; gnt_o mirrors req_i
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready_i or timeout
// RESP   | one-cycle r_valid_o pulse, timer cleared
module apb_per_bridge
  import apb_per_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_RDATA_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [BE_WIDTH-1:0]   pstrb_o,
  output logic                  psel_o,
  output logic                  penable_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [BE_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmr_en, tmr_clr, tmr_expired;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) i_timeout_cnt (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .en_i     (tmr_en),
    .clr_i    (tmr_clr),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    r_valid_o = 1'b0;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          paddr_d  = add_i;
          pwrite_d = ~wen_i;
          pwdata_d = wdata_i;
          // Reads drive no strobes on APB4.
          pstrb_d  = wen_i ? '0 : be_i;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        // A ready slave on the limit cycle still completes normally.
        if (pready_i) begin
          rdata_d = prdata_i;
          err_d   = pslverr_i;
          state_d = RESP;
        end else if (tmr_expired) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RESP: begin
        r_valid_o = 1'b1;
        tmr_clr   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign paddr_o   = paddr_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;
  assign r_rdata_o = rdata_q;
  assign r_err_o   = err_q;

endmodule

// File: tb/tb_apb_per_bridge.sv
// Directed bench for apb_per_bridge with a cycle-age transaction model checked every cycle.
module tb_apb_per_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt_o, r_valid_o, r_err_o, pwrite_o, psel_o, penable_o;
  logic [31:0] r_rdata_o, paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  apb_per_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_err_o(r_err_o), .paddr_o(paddr_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .psel_o(psel_o), .penable_o(penable_o), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave: answers after `waits` not-ready access cycles; force_pready injects a stray ready.
  int          waits = 0;
  int          acc_cnt;
  logic        force_pready = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  assign pready  = (psel_o && penable_o && (acc_cnt >= waits)) || force_pready;
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) acc_cnt <= 0;
    else if (psel_o && penable_o && !pready) acc_cnt <= acc_cnt + 1;
    else if (!psel_o) acc_cnt <= 0;
  end

  // Model: m_age counts cycles since grant (0 = idle); m_end is the age of the response cycle.
  int          m_age, m_end;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_write, m_err;
  logic [3:0]  m_strb;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_age <= 0; m_end <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
      m_write <= 1'b0; m_err <= 1'b0; m_strb <= '0;
    end else if (m_age == 0) begin
      if (req) begin
        m_addr  <= add;
        m_write <= ~wen;
        m_wdata <= wdata;
        m_strb  <= wen ? 4'b0000 : be;
        m_age   <= 1;
      end
    end else if (m_end != 0 && m_age == m_end) begin
      m_age <= 0;
      m_end <= 0;
    end else begin
      if (m_age >= 2 && m_end == 0) begin
        if (pready) begin
          m_rdata <= prdata;
          m_err   <= pslverr;
          m_end   <= m_age + 1;
        end else if (m_age - 1 == TO) begin
          m_rdata <= 32'hDEAD_BEEF;
          m_err   <= 1'b1;
          m_end   <= m_age + 1;
        end
      end
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    chk("gnt",     gnt_o,     (m_age == 0) && req);
    chk("psel",    psel_o,    (m_age >= 1) && (m_end == 0));
    chk("penable", penable_o, (m_age >= 2) && (m_end == 0));
    chk("r_valid", r_valid_o, (m_age != 0) && (m_age == m_end));
    chk("paddr",   paddr_o,   m_addr);
    chk("pwrite",  pwrite_o,  m_write);
    chk("pwdata",  pwdata_o,  m_wdata);
    chk("pstrb",   pstrb_o,   m_strb);
    chk("r_rdata", r_rdata_o, m_rdata);
    chk("r_err",   r_err_o,   m_err);
  end

  // which: 0 = wait for gnt_o, 1 = wait for r_valid_o; returns the cycle it was seen.
  task automatic wait_sig(input bit which, output int at);
    bit got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((which == 1'b0 && gnt_o) || (which == 1'b1 && r_valid_o)) begin
        got = 1'b1;
        break;
      end
    end
    at = cyc;
    chk(which ? "wait_rvalid" : "wait_gnt", got, 1'b1);
  endtask

  task automatic xfer(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, input int w, input bit se, input logic [31:0] rdv,
                      input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    int g, r;
    waits = w; slv_err = se; slv_rdata = rdv;
    @(posedge clk); #1;
    req = 1'b1; add = a; wen = rd; wdata = wd; be = b;
    wait_sig(1'b0, g);
    @(posedge clk); #1;
    req = 1'b0;
    wait_sig(1'b1, r);
    chk("lit_rdata",   r_rdata_o, exp_rd);
    chk("lit_err",     r_err_o,   exp_err);
    chk("lit_latency", r - g,     exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int g1, r1, g2, r2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt_o, 0);       chk("rst_rvalid", r_valid_o, 0);
    chk("rst_psel", psel_o, 0);     chk("rst_pen", penable_o, 0);
    chk("rst_pwrite", pwrite_o, 0); chk("rst_paddr", paddr_o, 0);
    chk("rst_rdata", r_rdata_o, 0); chk("rst_err", r_err_o, 0);
    chk("rst_pstrb", pstrb_o, 0);   chk("rst_pwdata", pwdata_o, 0);
    rst_ni = 1'b1;

    xfer(1, 32'h1A10_0004, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 32'h1234_5678, 0, 3);
    xfer(0, 32'h1A10_0008, 32'hCAFE_F00D, 4'b0011, 2, 0, 32'h0BAD_0000, 32'h0BAD_0000, 0, 5);
    xfer(1, 32'h1A10_000C, 32'h0, 4'hF, 0, 1, 32'h5555_AAAA, 32'h5555_AAAA, 1, 3);
    xfer(1, 32'h1A10_0010, 32'h0, 4'hF, 0, 0, 32'h0000_1111, 32'h0000_1111, 0, 3);
    // Stuck slave: timeout after TO access cycles.
    xfer(1, 32'h1A10_0014, 32'h0, 4'hF, 100, 0, 32'h7777_7777, 32'hDEAD_BEEF, 1, 6);
    @(posedge clk); #1 force_pready = 1'b1;
    @(posedge clk); #1 force_pready = 1'b0;
    xfer(1, 32'h1A10_0018, 32'h0, 4'hF, 0, 0, 32'hA5A5_0001, 32'hA5A5_0001, 0, 3);
    // Ready on the limit cycle beats the timeout.
    xfer(1, 32'h1A10_001C, 32'h0, 4'hF, 3, 0, 32'h4242_4242, 32'h4242_4242, 0, 6);

    // Back-to-back with req held high.
    waits = 0; slv_err = 1'b0; slv_rdata = 32'h0102_0304;
    @(posedge clk); #1;
    req = 1'b1; add = 32'h1A10_0020; wen = 1'b1; wdata = '0; be = 4'hF;
    wait_sig(1'b0, g1);
    @(posedge clk); #1;
    add = 32'h1A10_0024; wen = 1'b0; wdata = 32'h1357_9BDF; be = 4'b1100;
    wait_sig(1'b1, r1);
    chk("b2b_rdata1", r_rdata_o, 32'h0102_0304);
    wait_sig(1'b0, g2);
    chk("b2b_gap", g2 - r1, 1);
    chk("b2b_lat1", r1 - g1, 3);
    @(posedge clk); #1;
    req = 1'b0;
    chk("b2b_pstrb", pstrb_o, 4'b1100);
    wait_sig(1'b1, r2);
    chk("b2b_lat2", r2 - g2, 3);

    // Reset in the middle of ACCESS.
    waits = 100; slv_rdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    req = 1'b1; add = 32'h1A10_0028; wen = 1'b1;
    wait_sig(1'b0, g1);
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_pen", penable_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_psel", psel_o, 0);
    chk("arst_pen", penable_o, 0);
    chk("arst_rvalid", r_valid_o, 0);
    chk("arst_paddr", paddr_o, 0);
    @(posedge clk); #1 rst_ni = 1'b1;
    xfer(1, 32'h1A10_002C, 32'h0, 4'hF, 0, 0, 32'h0BEE_F00D, 32'h0BEE_F00D, 0, 3);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
